// File: rtl/ysyx_220053_pkg.sv
// Shared state encoding and halt reasons for the multi-cycle sequencer.
package ysyx_220053_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;

endpackage

// File: rtl/ysyx_220053_wait_timer.sv
// Handshake wait counter: counts req-without-ack cycles, flags the cycle that would reach TIMEOUT.
// expired is combinational on en so an ack in that same cycle still wins.
module ysyx_220053_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_220053_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: 4 cycles per ALU op, +waits on memory handshakes.
// req held until ack; a handshake stalled for TIMEOUT cycles halts the core.
module ysyx_220053_mc_sequencer
  import ysyx_220053_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic             dec_wen,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_wen,
  output logic             pc_we,
  output logic             halted,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // The PC register lives in the datapath; only its alignment matters here.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  state_t     state, state_nxt;
  logic [1:0] code_q, code_nxt;
  logic       wen_q, store_q;
  logic       retire;
  logic       wait_en, wait_clr, wait_expired;

  assign imem_req  = (state == FETCH);
  assign dmem_req  = (state == MEM);
  assign dmem_we   = dmem_req & store_q;
  assign ir_we     = imem_req & imem_ack;
  assign pc_we     = (state == WB);
  assign rf_wen    = pc_we & wen_q & ~store_q;
  assign halted    = (state == HALT);
  assign halt_code = code_q;

  assign wait_en  = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);
  assign wait_clr = (state_nxt != state);

  ysyx_220053_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wait_clr),
    .en     (wait_en),
    .expired(wait_expired)
  );

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          state_nxt = DECODE;
        end else if (wait_expired) begin
          state_nxt = HALT;
          code_nxt  = HALT_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          state_nxt = HALT;
          code_nxt  = HALT_ILLEGAL;
        end else if (dec_ebreak) begin
          // ebreak counts as retired even though it never reaches WB
          state_nxt = HALT;
          code_nxt  = HALT_EBREAK;
          retire    = 1'b1;
        end else if (dec_load || dec_store) begin
          state_nxt = MEM;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = WB;
      MEM: begin
        if (dmem_ack) begin
          state_nxt = WB;
        end else if (wait_expired) begin
          state_nxt = HALT;
          code_nxt  = HALT_TIMEOUT;
        end
      end
      WB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      code_q      <= HALT_EBREAK;
      wen_q       <= 1'b0;
      store_q     <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      if (state == DECODE) begin
        wen_q   <= dec_wen;
        store_q <= dec_store;
      end
      if (state != HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (retire) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_mc_sequencer.sv
// Scoreboard bench: an open-loop driver pushes expected events, a negedge monitor pops and compares.
module tb_ysyx_220053_mc_sequencer;

  localparam int T  = 4;
  localparam int CW = 64;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBREAK = 3, K_ILL = 4, K_BOTH = 5;
  localparam int EV_FETCH = 0, EV_MEM = 1, EV_WB = 2, EV_HALT = 3;

  logic          clk, rst_n;
  logic          imem_req, imem_ack, ir_we;
  logic          dec_wen, dec_load, dec_store, dec_ebreak, dec_illegal;
  logic          dmem_req, dmem_we, dmem_ack;
  logic          rf_wen, pc_we, halted;
  logic [1:0]    halt_code;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  ysyx_220053_mc_sequencer #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (T),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .ir_we      (ir_we),
    .dec_wen    (dec_wen),
    .dec_load   (dec_load),
    .dec_store  (dec_store),
    .dec_ebreak (dec_ebreak),
    .dec_illegal(dec_illegal),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_wen     (rf_wen),
    .pc_we      (pc_we),
    .halted     (halted),
    .halt_code  (halt_code),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         len;
    logic       flag;
    logic [1:0] code;
    logic [63:0] ret;
    logic [63:0] cyc;
  } ev_t;

  typedef struct {
    int   kind;
    logic wen;
    int   fd;
    int   md;
  } instr_t;

  ev_t    sb[$];
  instr_t prog[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  logic [63:0] m_t, m_ret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int len, input logic flag, input logic [1:0] code);
    ev_t e;
    e.kind = kind; e.len = len; e.flag = flag; e.code = code;
    e.ret = m_ret; e.cyc = m_t;
    sb.push_back(e);
  endtask

  task automatic pop_ev(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got event kind %0d required none (t=%0t)", kind, $time);
    end else begin
      e = sb.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    int   ireq_len, dreq_len;
    logic halted_q;
    ev_t  e;
    bit   ok;
    ireq_len = 0; dreq_len = 0; halted_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ireq_len = 0; dreq_len = 0; halted_q = 1'b0;
      end else begin
        ireq_len = imem_req ? ireq_len + 1 : 0;
        dreq_len = dmem_req ? dreq_len + 1 : 0;
        if (imem_req && imem_ack) begin
          pop_ev(EV_FETCH, e, ok);
          if (ok) begin
            check("ir_we_on_ack", 64'(ir_we), 64'd1);
            check("imem_req_len", 64'(ireq_len), 64'(e.len));
          end
        end
        if (dmem_req && dmem_ack) begin
          pop_ev(EV_MEM, e, ok);
          if (ok) begin
            check("dmem_we", 64'(dmem_we), 64'(e.flag));
            check("dmem_req_len", 64'(dreq_len), 64'(e.len));
          end
        end
        if (pc_we) begin
          pop_ev(EV_WB, e, ok);
          if (ok) begin
            check("rf_wen", 64'(rf_wen), 64'(e.flag));
            check("wb_instret", instret_cnt, e.ret);
            check("wb_cycle", cycle_cnt, e.cyc);
          end
        end
        if (halted && !halted_q) begin
          pop_ev(EV_HALT, e, ok);
          if (ok) begin
            check("halt_code", 64'(halt_code), 64'(e.code));
            check("halt_instret", instret_cnt, e.ret);
            check("halt_cycle", cycle_cnt, e.cyc);
            check("halt_no_req", 64'({imem_req, dmem_req}), 64'd0);
          end
        end
        halted_q = halted;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_wen = 1'b0; dec_load = 1'b0; dec_store = 1'b0; dec_ebreak = 1'b0; dec_illegal = 1'b0;
    #1;
    check("rst_strobes", 64'({dmem_req, dmem_we, rf_wen, pc_we, ir_we}), 64'd0);
    check("rst_halt", 64'({halted, halt_code}), 64'd0);
    check("rst_counters", cycle_cnt | instret_cnt, 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_t = 0; m_ret = 0;
  endtask

  // Reference model: cycle costs follow the phase rules directly.
  task automatic run_instr(input instr_t in, output bit done);
    bit is_mem;
    done = 1'b1;
    is_mem = (in.kind == K_LOAD) || (in.kind == K_STORE);
    dec_wen     = in.wen;
    dec_load    = (in.kind == K_LOAD);
    dec_store   = (in.kind == K_STORE);
    dec_ebreak  = (in.kind == K_EBREAK) || (in.kind == K_BOTH);
    dec_illegal = (in.kind == K_ILL) || (in.kind == K_BOTH);
    if (in.fd >= T) begin
      m_t += T;
      push(EV_HALT, 0, 1'b0, 2'd2);
      imem_ack = 1'b0;
      repeat (T) step();
      return;
    end
    push(EV_FETCH, in.fd + 1, 1'b0, 2'd0);
    imem_ack = 1'b0;
    repeat (in.fd) step();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    m_t += 64'(in.fd + 2);
    step();
    if (dec_illegal) begin
      push(EV_HALT, 0, 1'b0, 2'd1);
      return;
    end
    if (dec_ebreak) begin
      m_ret += 1;
      push(EV_HALT, 0, 1'b0, 2'd0);
      return;
    end
    if (is_mem) begin
      if (in.md >= T) begin
        m_t += T;
        push(EV_HALT, 0, 1'b0, 2'd2);
        repeat (T) step();
        return;
      end
      push(EV_MEM, in.md + 1, in.kind == K_STORE, 2'd0);
      repeat (in.md) step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      m_t += 64'(in.md + 1);
    end else begin
      step();
      m_t += 1;
    end
    push(EV_WB, 0, in.wen && (in.kind != K_STORE), 2'd0);
    step();
    m_t += 1;
    m_ret += 1;
    done = 1'b0;
  endtask

  task automatic run_prog();
    bit done;
    do_reset();
    done = 1'b0;
    foreach (prog[i]) begin
      if (!done) run_instr(prog[i], done);
    end
    // Acks arriving in HALT must be ignored and counters stay frozen.
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("halt_ir_we", 64'({ir_we, pc_we, rf_wen}), 64'd0);
      check("halt_frozen", {cycle_cnt[31:0], instret_cnt[31:0]}, {m_t[31:0], m_ret[31:0]});
      step();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    prog.delete();
  endtask

  function automatic instr_t mk(input int kind, input logic wen, input int fd, input int md);
    instr_t r;
    r.kind = kind; r.wen = wen; r.fd = fd; r.md = md;
    return r;
  endfunction

  function automatic int rnd_delay();
    return ($urandom_range(0, 11) == 0) ? T : int'($urandom_range(0, T - 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_wen = 1'b0; dec_load = 1'b0; dec_store = 1'b0; dec_ebreak = 1'b0; dec_illegal = 1'b0;
    m_t = 0; m_ret = 0;
    repeat (2) @(posedge clk);

    // ALU stream then ebreak after the third addi
    for (int i = 0; i < 3; i++) prog.push_back(mk(K_ALU, 1'b1, 0, 0));
    prog.push_back(mk(K_EBREAK, 1'b0, 0, 0));
    run_prog();

    // load with waits, store with dec_wen set, then illegal
    prog.push_back(mk(K_LOAD, 1'b1, 0, T - 1));
    prog.push_back(mk(K_STORE, 1'b1, 0, 0));
    prog.push_back(mk(K_ILL, 1'b0, 0, 0));
    run_prog();

    // fetch timeout after one addi
    prog.push_back(mk(K_ALU, 1'b1, 0, 0));
    prog.push_back(mk(K_ALU, 1'b1, 99, 0));
    run_prog();

    // ack on the last allowed cycle, then a data-side timeout
    prog.push_back(mk(K_ALU, 1'b0, T - 1, 0));
    prog.push_back(mk(K_LOAD, 1'b1, 1, T - 1));
    prog.push_back(mk(K_STORE, 1'b0, 0, T));
    run_prog();

    // illegal wins over ebreak, no retire
    prog.push_back(mk(K_ALU, 1'b1, 1, 0));
    prog.push_back(mk(K_BOTH, 1'b1, 0, 0));
    run_prog();

    // reset asserted while a load is in MEM
    do_reset();
    dec_load = 1'b1; dec_wen = 1'b1;
    push(EV_FETCH, 1, 1'b0, 2'd0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    check("mem_entered", 64'(dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dmem_req", 64'({dmem_req, pc_we, rf_wen}), 64'd0);
    check("midrst_counters", cycle_cnt | instret_cnt, 64'd0);
    check("midrst_sb", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dec_load = 1'b0; dec_wen = 1'b0;
    check("rel_fetch", 64'(imem_req), 64'd1);
    step();
    check("rel_cycle1", cycle_cnt, 64'd1);
    check("rel_instret", instret_cnt, 64'd0);

    // randomized programs
    for (int r = 0; r < 14; r++) begin
      int n;
      n = int'($urandom_range(2, 8));
      for (int i = 0; i < n; i++)
        prog.push_back(mk(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rnd_delay(), rnd_delay()));
      prog.push_back(mk(int'($urandom_range(3, 5)), 1'b0, int'($urandom_range(0, 2)), 0));
      run_prog();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
